// File: rtl/pattern_search_top.sv
// Counts in-byte, per-byte and stream-wide matches of a 5-bit pattern
// in a 32-byte message held in the internal memory dm1.
module pattern_search_dmem (
    input  logic       clk_i,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] raddr_i,
    output logic [7:0] rdata_o
);
    logic [7:0] core [0:256-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            core[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = core[raddr_i];
endmodule

module pattern_search_top (
    input  logic clk,
    input  logic reset,
    output logic done
);
    typedef enum logic [2:0] {
        INIT, SCAN, WR33, WR34, WR35, DONE
    } state_t;

    state_t      state_q;
    logic [4:0]  idx_q;
    logic [4:0]  p_q;
    logic [7:0]  prev_q;
    logic [7:0]  ctb_q, cto_q, cts_q;
    logic [7:0]  ctb_d, cto_d, cts_d;
    logic        done_q;

    logic [7:0]  raddr, rdata;
    logic        we;
    logic [7:0]  waddr, wdata;
    logic [2:0]  in_cnt, x_cnt;
    logic [15:0] win;

    pattern_search_dmem dm1 (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // INIT reads the pattern byte; SCAN walks the message
    assign raddr = (state_q == INIT) ? 8'd32 : {3'b000, idx_q};

    always_comb begin
        in_cnt = 3'd0;
        x_cnt  = 3'd0;
        win    = {prev_q, rdata};
        for (int k = 0; k < 4; k++) begin
            if (rdata[k+:5] == p_q) in_cnt = in_cnt + 3'd1;
        end
        // windows straddling the byte boundary only
        for (int k = 4; k < 8; k++) begin
            if (win[k+:5] == p_q) x_cnt = x_cnt + 3'd1;
        end
        ctb_d = ctb_q + {5'd0, in_cnt};
        cto_d = cto_q + {7'd0, (in_cnt != 3'd0)};
        cts_d = cts_q + {5'd0, in_cnt}
              + ((idx_q != 5'd0) ? {5'd0, x_cnt} : 8'd0);
    end

    always_comb begin
        we    = 1'b0;
        waddr = 8'd0;
        wdata = 8'd0;
        unique case (state_q)
            WR33: begin we = 1'b1; waddr = 8'd33; wdata = ctb_q; end
            WR34: begin we = 1'b1; waddr = 8'd34; wdata = cto_q; end
            WR35: begin we = 1'b1; waddr = 8'd35; wdata = cts_q; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            idx_q   <= 5'd0;
            p_q     <= 5'd0;
            prev_q  <= 8'd0;
            ctb_q   <= 8'd0;
            cto_q   <= 8'd0;
            cts_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                INIT: begin
                    p_q     <= rdata[7:3];
                    idx_q   <= 5'd0;
                    state_q <= SCAN;
                end
                SCAN: begin
                    ctb_q  <= ctb_d;
                    cto_q  <= cto_d;
                    cts_q  <= cts_d;
                    prev_q <= rdata;
                    idx_q  <= idx_q + 5'd1;
                    if (idx_q == 5'd31) state_q <= WR33;
                end
                WR33: state_q <= WR34;
                WR34: state_q <= WR35;
                WR35: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: state_q <= DONE;
                default: state_q <= INIT;
            endcase
        end
    end

    assign done = done_q;
endmodule

// File: tb/tb_pattern_search_top.sv
// Directed bench for pattern_search_top: preloads dm1.core and checks
// the three counts, done latency and reset behaviour.
module tb_pattern_search_top;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic done;

    int vecs = 0;
    int errs = 0;
    logic [7:0] msg [0:32];
    logic [7:0] hi [36:255];

    pattern_search_top dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load();
        for (int i = 0; i <= 32; i++) dut.dm1.core[i] = msg[i];
        for (int i = 33; i <= 35; i++) dut.dm1.core[i] = 8'hAA;
    endtask

    task automatic fill(input logic [7:0] b, input logic [7:0] pat);
        for (int i = 0; i < 32; i++) msg[i] = b;
        msg[32] = pat;
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk({tag, "_done_in_reset"}, int'(done), 0);
        reset = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 36);
    endtask

    task automatic check_res(input string tag, input int b, input int o,
                             input int s);
        chk({tag, "_ctb"}, int'(dut.dm1.core[33]), b);
        chk({tag, "_cto"}, int'(dut.dm1.core[34]), o);
        chk({tag, "_cts"}, int'(dut.dm1.core[35]), s);
    endtask

    // reference: CTS from the flat 256-bit stream, not per byte pair
    task automatic model(output int b, output int o, output int s);
        logic [255:0] str;
        logic [4:0]   p;
        int           n;
        p = msg[32][7:3];
        b = 0; o = 0; s = 0;
        for (int i = 0; i < 32; i++) begin
            str[255 - 8*i -: 8] = msg[i];
            n = 0;
            for (int k = 0; k < 4; k++)
                if (msg[i][k+:5] == p) n++;
            b += n;
            if (n > 0) o++;
        end
        for (int j = 0; j < 252; j++)
            if (str[255 - j -: 5] == p) s++;
    endtask

    initial begin
        int eb, eo, es, bad, drops;

        fill(8'h00, 8'h00);
        load();
        @(negedge clk);
        chk("reset_done", int'(done), 0);
        pulse_reset("zeros");
        wait_done("zeros");
        check_res("zeros", 128, 32, 252);

        fill(8'hFF, 8'h20);
        load();
        pulse_reset("ones");
        wait_done("ones");
        check_res("ones", 0, 0, 0);

        fill(8'h55, 8'hA8);
        load();
        pulse_reset("alt");
        wait_done("alt");
        check_res("alt", 64, 32, 126);

        fill(8'h00, 8'h27);
        msg[0] = 8'h01;
        load();
        pulse_reset("cross");
        wait_done("cross");
        check_res("cross", 0, 0, 1);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i <= 32; i++) msg[i] = 8'($urandom);
            if (r == 0) msg[32] = {msg[5][6:2], 3'b101};
            for (int i = 36; i < 256; i++) begin
                hi[i] = 8'($urandom);
                dut.dm1.core[i] = hi[i];
            end
            load();
            model(eb, eo, es);
            pulse_reset("rand");
            wait_done("rand");
            check_res("rand", eb, eo, es);
            bad = 0;
            for (int i = 36; i < 256; i++)
                if (dut.dm1.core[i] !== hi[i]) bad++;
            chk("rand_upper_untouched", bad, 0);
        end

        for (int i = 0; i <= 32; i++) msg[i] = 8'($urandom);
        load();
        model(eb, eo, es);
        pulse_reset("mid");
        repeat (11) @(negedge clk);
        chk("mid_done_scan", int'(done), 0);
        pulse_reset("mid2");
        wait_done("mid");
        check_res("mid", eb, eo, es);
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done !== 1'b1) drops++;
        end
        chk("done_hold", drops, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/pattern_search_top.md
# pattern_search_top

Self-contained accelerator that counts occurrences of a 5-bit pattern in a 32-byte message held in its internal data memory. After a reset pulse it scans bytes 0–31 and writes three 8-bit counts to bytes 33–35. It then raises `done`. The bench preloads and inspects memory hierarchically through instance `dm1`, array `core`.

## Interface
- No parameters.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; starts or restarts the program.
- `done`  out  1  high when all three results are written; held until the next reset.
- Internal memory instance `dm1`, declared as `logic [7:0] core [0:256-1]`.
  - Hierarchical path `dm1.core` must exist exactly so.
  - Combinational read, synchronous single write port.
  - No reset of contents.

## Operation
- Memory map:
  - core[0..31]: message bytes.
  - core[32][7:3]: pattern P; bits [2:0] ignored.
  - core[33]: CTB.
  - core[34]: CTO.
  - core[35]: CTS.
  - All other bytes are never written.
- Message bit string S (256 bits): core[0] is most significant; bit 7 of each byte precedes bit 0.
- CTB, in-byte matches: for each byte b, count k in 0..3 where b[k+4:k]==P.
  - Sum over all 32 bytes.
  - Maximum 128; the register is 8 bits.
- CTO: number of bytes with at least one in-byte match. Range 0..32.
- CTS, matches with byte crossing: count all 252 5-bit windows of S equal to P.
  - Compute as CTB plus crossing windows.
  - For each i in 1..31, form W={core[i-1],core[i]} (16 bits).
  - Count k in 4..7 where W[k+4:k]==P.
  - Maximum 252.
- FSM states: INIT, SCAN, WR33, WR34, WR35, DONE.
  - INIT, entered on any edge with reset=1:
    - Clear counters and byte index.
    - Clear prev-byte register.
    - done=0.
  - INIT → SCAN, on the first edge with reset=0:
    - Latch P=core[32][7:3].
    - Set index=0.
  - SCAN, one byte per cycle, idx 0..31:
    - Read cur=core[idx].
    - Add in-byte matches to CTB and CTS.
    - Increment CTO if any in-byte match.
    - If idx>0, add crossing matches from {prev,cur} to CTS.
    - Store prev=cur.
    - After idx 31, go to WR33.
  - WR33, WR34, WR35: write CTB, CTO, CTS respectively, one per cycle, in that order.
  - DONE: terminal state, no memory writes; leave only on reset.
- Counts are 8-bit unsigned; they cannot overflow given the maxima above.
- Reset mid-operation: abandon the scan and return to INIT. Memory bytes already written stay as written. A fresh run overwrites 33..35.

## Timing
- Reset values: done=0, state=INIT, counters=0.
- Count rising edges from the first edge sampling reset=0 (edge 1):
  - Edge 1: INIT→SCAN.
  - Edges 2–33: scan bytes 0..31.
  - Edges 34–36: write core[33], core[34], core[35].
  - done is registered (state==DONE) and becomes 1 after edge 36.
- Latency: 36 cycles from reset release to done.
- A one-cycle reset pulse is sufficient. A reset held for multiple cycles keeps the block in INIT.
- The bench may modify core[0..32] only while reset=1 or before reset. Changes made during SCAN are undefined.

## Test plan
- All bytes 0x00, core[32]=0x00 (P=00000) → core[33]=128, core[34]=32, core[35]=252; done after 36 cycles.
- All bytes 0xFF, P=00100 → 0, 0, 0.
- All bytes 0x55, P=10101 → CTB=64, CTO=32, CTS=126.
- core[0]=0x01, core[1..31]=0x00, P=00100 → CTB=0, CTO=0, CTS=1 (crossing window only).
- Random bytes and random P → results match a software model of the three definitions; core[36..255] unchanged.
- Assert reset at SCAN idx 10, release, run to done:
  - done drops while reset=1.
  - Final results are identical to an uninterrupted run.
  - done remains 1 for 100 idle cycles.
